wb_uart: RTL

WB_UART -- requirements
Module: wb_uart

---
 rtl/wb_uart.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart.sv
// Wishbone-attached UART: 16-bit register port, 8N1 TX/RX with a byte FIFO each way.
// Bit period is a programmable divisor; sticky error bits clear on STATUS read.
module wb_uart_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       empty_o,
    output logic       full_o
);
    logic [7:0]  mem_q [2**AW];
    logic [AW:0] wp_q, rp_q;
    logic        push_ok, pop_ok;

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    // A pop frees the slot in the same cycle, so push is still accepted when full.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + 1'b1;
            if (pop_ok)  rp_q <= rp_q + 1'b1;
        end
    end
endmodule

module wb_uart #(
    parameter int CLK_DIV_RST = 1736,
    parameter int FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [13:0] wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_e;

    logic        acc_prev_q;
    logic [15:0] rdata_q, rdata_d, div_q, div_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, txovf_q, txovf_d;

    st_e         tx_st_q, tx_st_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_pop, tx_end;

    st_e         rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_bad_q, rx_bad_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s, rx_push, ferr_set, rx_end;

    logic        acc, wr, rd;
    logic [1:0]  adr;
    logic        tx_push, rx_pop;
    logic [7:0]  tx_dout, rx_dout;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [15:0] status;
    logic        unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_adr_i[13:2]};

    // Side effects only on the first strobed cycle of a bus access.
    assign acc     = wb_stb_i && wb_cyc_i && !acc_prev_q;
    assign wr      = acc && wb_we_i;
    assign rd      = acc && !wb_we_i;
    assign adr     = wb_adr_i[1:0];
    assign tx_push = wr && (adr == 2'd0);
    assign rx_pop  = rd && (adr == 2'd0);

    wb_uart_fifo #(.AW(FIFO_AW)) u_txf (
        .clk(clk), .resetn(resetn), .push_i(tx_push), .din_i(wb_dat_i[7:0]),
        .pop_i(tx_pop), .dout_o(tx_dout), .empty_o(tx_empty), .full_o(tx_full)
    );
    wb_uart_fifo #(.AW(FIFO_AW)) u_rxf (
        .clk(clk), .resetn(resetn), .push_i(rx_push), .din_i(rx_sh_q),
        .pop_i(rx_pop), .dout_o(rx_dout), .empty_o(rx_empty), .full_o(rx_full)
    );

    assign status = {8'h00, txovf_q, ferr_q, ovr_q, (tx_st_q != S_IDLE),
                     tx_empty, tx_full, rx_full, !rx_empty};
    assign irq      = !rx_empty || ovr_q || ferr_q || txovf_q;
    assign wb_dat_o = rdata_q;
    assign uart_tx  = (tx_st_q == S_START) ? 1'b0 :
                      (tx_st_q == S_DATA)  ? tx_sh_q[0] : 1'b1;

    always_comb begin
        rdata_d = rdata_q;
        div_d   = div_q;
        ovr_d   = ovr_q;
        ferr_d  = ferr_q;
        txovf_d = txovf_q;
        if (rd) begin
            case (adr)
                2'd0:    rdata_d = {8'h00, rx_empty ? 8'h00 : rx_dout};
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = div_q;
                default: rdata_d = 16'h0000;
            endcase
            if (adr == 2'd1) begin
                ovr_d   = 1'b0;
                ferr_d  = 1'b0;
                txovf_d = 1'b0;
            end
        end
        if (wr && adr == 2'd2) div_d = (wb_dat_i < 16'd16) ? 16'd16 : wb_dat_i;
        // New events win over a same-cycle clear so none are lost.
        if (tx_push && tx_full && !tx_pop) txovf_d = 1'b1;
        if (rx_push && rx_full && !rx_pop) ovr_d = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
    end

    assign tx_end = (tx_cnt_q == tx_div_q - 16'd1);

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            S_IDLE: if (!tx_empty) begin
                tx_pop   = 1'b1;
                tx_div_d = div_q;
                tx_sh_d  = tx_dout;
                tx_cnt_d = '0;
                tx_st_d  = S_START;
            end
            S_START: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_bit_d = '0;
                    tx_st_d  = S_DATA;
                end
            end
            S_DATA: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_end) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
                end
            end
            default: begin
                tx_cnt_d = tx_cnt_q + 16'd1;
                if (tx_end) tx_st_d = S_IDLE;
            end
        endcase
    end

    assign rx_s    = rx_sync_q[1];
    assign rx_half = {1'b0, rx_div_q[15:1]} - 16'd1;
    assign rx_end  = (rx_cnt_q == rx_div_q - 16'd1);

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_bad_d = rx_bad_q;
        rx_push  = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s) begin
                rx_st_d  = S_START;
                rx_cnt_d = '0;
                rx_div_d = div_q;
            end
            S_START: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if (rx_cnt_q == rx_half) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                if (rx_end) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                end
            end
            default: begin
                // After a framing error, park here until the line idles high.
                if (rx_bad_q) begin
                    if (rx_s) begin
                        rx_bad_d = 1'b0;
                        rx_st_d  = S_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    if (rx_end) begin
                        if (rx_s) begin
                            rx_push = 1'b1;
                            rx_st_d = S_IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            rx_bad_d = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_prev_q <= 1'b0;
            rdata_q    <= '0;
            div_q      <= 16'(CLK_DIV_RST);
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            txovf_q    <= 1'b0;
            tx_st_q    <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'd16;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            rx_st_q    <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'd16;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_bad_q   <= 1'b0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            acc_prev_q <= wb_stb_i && wb_cyc_i;
            rdata_q    <= rdata_d;
            div_q      <= div_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            txovf_q    <= txovf_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_bad_q   <= rx_bad_d;
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
        end
    end
endmodule
